// File: rtl/ser_collect_pkg.sv
// ============================================================================
// Module : ser_collect_pkg
// Brief  : Shared state encoding and sizing helper for serial_word_collector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ser_collect_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    FULL   = 2'd3
  } ser_state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ser_shift_reg.sv
// ============================================================================
// Module : ser_shift_reg
// Brief  : WIDTH-bit MSB-first shift register with load and shift enables.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ser_shift_reg
  import ser_collect_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_next_o
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (WIDTH == 1) begin : g_single
      assign w_shifted = bit_i;
    end else begin : g_multi
      assign w_shifted = {shift_q[WIDTH-2:0], bit_i};
    end
  endgenerate

  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d    = '0;
      shift_d[0] = bit_i;
    end else if (shift_i) begin
      shift_d = w_shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  // Exposing the next value lets the owner capture a word on its final beat.
  assign word_next_o = shift_d;

endmodule

`default_nettype wire

// File: rtl/serial_word_collector.sv
// ============================================================================
// Module : serial_word_collector
// Brief  : Framed serial-to-parallel collector with valid/ready word output.
//          Define SER_PARITY_EN to require an even-parity beat after each word.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_word_collector
  import ser_collect_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_valid,
  input  logic             sin_bit,
  input  logic             sin_sof,
  output logic             sin_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             frame_err
);

  localparam int                 c_CNT_W = cnt_width(WIDTH);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  ser_state_t         state_q;
  logic [c_CNT_W-1:0] count_q;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               frame_err_q;
  logic               sin_ready_q;

  logic               w_beat;
  logic               w_load;
  logic               w_shift;
  logic               w_data_done;
  logic [WIDTH-1:0]   w_shift_d;

  assign w_beat  = sin_valid && sin_ready_q;
  assign w_load  = w_beat && sin_sof;
  assign w_shift = w_beat && !sin_sof && (state_q == SHIFT);

  // Beat that supplies the last data bit of a word (a lone sof bit when WIDTH==1).
  assign w_data_done = w_beat && (sin_sof ? (WIDTH == 1)
                                          : ((state_q == SHIFT) && (count_q == c_LAST)));

`ifdef SER_PARITY_EN
  logic w_parity_ok;
  // Register is idle during a non-sof parity beat, so the next value is the word.
  assign w_parity_ok = (sin_bit == ^w_shift_d);
`endif

  ser_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (w_load),
    .shift_i     (w_shift),
    .bit_i       (sin_bit),
    .word_next_o (w_shift_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
      sin_ready_q <= 1'b1;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE, SHIFT, PARITY: begin
          if (w_beat && sin_sof) begin
            count_q     <= c_ONE;
            state_q     <= SHIFT;
            frame_err_q <= (state_q != IDLE);
          end else if (w_beat && (state_q == SHIFT)) begin
            count_q <= count_q + c_ONE;
          end
`ifdef SER_PARITY_EN
          else if (w_beat && (state_q == PARITY)) begin
            if (w_parity_ok) begin
              state_q     <= FULL;
              out_valid_q <= 1'b1;
              sin_ready_q <= 1'b0;
              out_data_q  <= w_shift_d;
            end else begin
              state_q     <= IDLE;
              count_q     <= '0;
              frame_err_q <= 1'b1;
            end
          end
`endif
          if (w_data_done) begin
`ifdef SER_PARITY_EN
            state_q     <= PARITY;
`else
            state_q     <= FULL;
            out_valid_q <= 1'b1;
            sin_ready_q <= 1'b0;
            out_data_q  <= w_shift_d;
`endif
          end
        end
        FULL: begin
          if (out_ready) begin
            state_q     <= IDLE;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            sin_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sin_ready = sin_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_collector.sv
// ============================================================================
// Module : tb_serial_word_collector
// Brief  : Directed and randomized checks of serial_word_collector (WIDTH=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_word_collector;

  localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
  localparam bit P_EN = 1'b1;
`else
  localparam bit P_EN = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic sof;
  } beat_t;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             sin_valid = 1'b0;
  logic             sin_bit   = 1'b0;
  logic             sin_sof   = 1'b0;
  logic             sin_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             frame_err;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] got_q[$];
  int               err_seen = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               exp_errs;
  beat_t            stim[$];

  logic [1:0] ready_mode = 2'd1;  // 0: hold low, 1: hold high, 2: random
  logic       rand_bit   = 1'b0;

  serial_word_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin_valid (sin_valid),
    .sin_bit   (sin_bit),
    .sin_sof   (sin_sof),
    .sin_ready (sin_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rand_bit <= 1'($urandom);
  assign out_ready = (ready_mode == 2'd2) ? rand_bit : ready_mode[0];

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (frame_err) err_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic even_par(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(w[i]);
    return logic'(n % 2);
  endfunction

  task automatic beat(input logic b, input logic sof);
    bit done = 1'b0;
    sin_valid = 1'b1;
    sin_bit   = b;
    sin_sof   = sof;
    for (int i = 0; i < 100 && !done; i++) begin
      done = sin_ready;
      tick();
    end
    sin_valid = 1'b0;
    sin_sof   = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL beat_timeout: sin_ready=%b required 1", sin_ready);
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) beat(w[i], i == WIDTH - 1);
    if (P_EN) beat(even_par(w), 1'b0);
  endtask

  // Reference: frames are sof-led MSB-first bit runs; parity (if enabled) is an extra beat.
  task automatic run_model();
    bit               in_frame = 1'b0;
    int               len      = 0;
    logic [WIDTH-1:0] word     = '0;
    exp_q.delete();
    exp_errs = 0;
    foreach (stim[k]) begin
      if (stim[k].sof) begin
        if (in_frame) exp_errs++;
        in_frame = 1'b1;
        word     = WIDTH'(stim[k].b);
        len      = 1;
      end else if (!in_frame) begin
        continue;
      end else if (len < WIDTH) begin
        word = WIDTH'(word * 2 + WIDTH'(stim[k].b));
        len++;
      end else begin
        if (stim[k].b == even_par(word)) exp_q.push_back(word);
        else exp_errs++;
        in_frame = 1'b0;
      end
      if (in_frame && len == WIDTH && !P_EN) begin
        exp_q.push_back(word);
        in_frame = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", frame_err); end
    if (sin_ready !== 1'b1) begin errors++; $display("FAIL rst_sin_ready: got %b want 1", sin_ready); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_assembly();
    logic [WIDTH-1:0] w  = 8'hB2;
    int               n0 = got_q.size();
    int               e0 = err_seen;
    ready_mode = 2'd1;
    for (int i = WIDTH - 1; i > 0; i--) beat(w[i], i == WIDTH - 1);
    if (P_EN) beat(w[0], 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL asm_early_valid: got %b want 0", out_valid); end
    if (P_EN) beat(even_par(w), 1'b0);
    else beat(w[0], 1'b0);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL asm_latency: out_valid got %b want 1", out_valid); end
    if (out_data !== 8'hB2) begin errors++; $display("FAIL asm_data: got %h want b2", out_data); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL asm_frame_err: got %b want 0", frame_err); end
    tick();
    checks += 3;
    if (got_q.size() != n0 + 1) begin errors++; $display("FAIL asm_count: got %0d words want 1", got_q.size() - n0); end
    else if (got_q[n0] !== 8'hB2) begin errors++; $display("FAIL asm_handoff: got %h want b2", got_q[n0]); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL asm_release: out_valid got %b want 0", out_valid); end
    if (err_seen != e0) begin errors++; $display("FAIL asm_errs: got %0d pulses want 0", err_seen - e0); end
  endtask

  task automatic test_backpressure();
    int n0 = got_q.size();
    ready_mode = 2'd0;
    send_word(8'hB2);
    for (int c = 0; c < 5; c++) begin
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
      if (out_data !== 8'hB2) begin errors++; $display("FAIL bp_data[%0d]: got %h want b2", c, out_data); end
      if (sin_ready !== 1'b0) begin errors++; $display("FAIL bp_sin_ready[%0d]: got %b want 0", c, sin_ready); end
      tick();
    end
    ready_mode = 2'd1;
    tick();
    checks += 3;
    if (sin_ready !== 1'b1) begin errors++; $display("FAIL bp_resume: sin_ready got %b want 1", sin_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid: got %b want 0", out_valid); end
    if (got_q.size() != n0 + 1) begin errors++; $display("FAIL bp_count: got %0d words want 1", got_q.size() - n0); end
  endtask

  task automatic test_restart();
    int n0 = got_q.size();
    int e0 = err_seen;
    ready_mode = 2'd1;
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    beat(1'b1, 1'b1);
    checks++;
    if (frame_err !== 1'b1) begin errors++; $display("FAIL rs_pulse: frame_err got %b want 1", frame_err); end
    beat(1'b1, 1'b0);
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rs_pulse_width: frame_err got %b want 0", frame_err); end
    for (int i = 0; i < WIDTH - 2; i++) beat(1'b1, 1'b0);
    if (P_EN) beat(even_par(8'hFF), 1'b0);
    tick(); tick();
    checks += 2;
    if (err_seen != e0 + 1) begin errors++; $display("FAIL rs_errs: got %0d pulses want 1", err_seen - e0); end
    if (got_q.size() != n0 + 1) begin errors++; $display("FAIL rs_count: got %0d words want 1", got_q.size() - n0); end
    else if (got_q[n0] !== 8'hFF) begin errors++; $display("FAIL rs_data: got %h want ff", got_q[n0]); end
  endtask

  task automatic test_idle_junk();
    int n0 = got_q.size();
    int e0 = err_seen;
    ready_mode = 2'd1;
    for (int i = 0; i < 4; i++) beat(1'($urandom), 1'b0);
    send_word(8'h5A);
    tick(); tick();
    checks += 2;
    if (got_q.size() != n0 + 1) begin errors++; $display("FAIL junk_count: got %0d words want 1", got_q.size() - n0); end
    else if (got_q[n0] !== 8'h5A) begin errors++; $display("FAIL junk_data: got %h want 5a", got_q[n0]); end
    if (err_seen != e0) begin errors++; $display("FAIL junk_errs: got %0d pulses want 0", err_seen - e0); end
  endtask

  task automatic test_reset_mid();
    int n0 = got_q.size();
    int e0 = err_seen;
    ready_mode = 2'd1;
    for (int i = 0; i < 5; i++) beat(1'($urandom), i == 0);
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    if (out_data !== '0) begin errors++; $display("FAIL rm_out_data: got %h want 00", out_data); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL rm_frame_err: got %b want 0", frame_err); end
    if (sin_ready !== 1'b1) begin errors++; $display("FAIL rm_sin_ready: got %b want 1", sin_ready); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_word(8'h3C);
    tick(); tick();
    checks += 2;
    if (got_q.size() != n0 + 1) begin errors++; $display("FAIL rm_count: got %0d words want 1", got_q.size() - n0); end
    else if (got_q[n0] !== 8'h3C) begin errors++; $display("FAIL rm_data: got %h want 3c", got_q[n0]); end
    if (err_seen != e0) begin errors++; $display("FAIL rm_errs: got %0d pulses want 0", err_seen - e0); end
  endtask

  task automatic test_parity_bad();
    logic [WIDTH-1:0] w  = 8'hB2;
    int               n0 = got_q.size();
    int               e0 = err_seen;
    ready_mode = 2'd1;
    for (int i = WIDTH - 1; i >= 0; i--) beat(w[i], i == WIDTH - 1);
    beat(~even_par(w), 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL par_valid: got %b want 0", out_valid); end
    tick(); tick();
    checks += 2;
    if (got_q.size() != n0) begin errors++; $display("FAIL par_count: got %0d words want 0", got_q.size() - n0); end
    if (err_seen != e0 + 1) begin errors++; $display("FAIL par_errs: got %0d pulses want 1", err_seen - e0); end
  endtask

  task automatic test_random();
    int  n0;
    int  e0;
    bit  drained = 1'b0;
    stim.delete();
    for (int i = 0; i < 300; i++) begin
      beat_t bt;
      bt.b   = 1'($urandom);
      bt.sof = (i == 0) || ($urandom_range(0, 11) == 0);
      stim.push_back(bt);
    end
    n0 = got_q.size();
    e0 = err_seen;
    ready_mode = 2'd2;
    foreach (stim[k]) begin
      if ($urandom_range(0, 3) == 0) tick();
      beat(stim[k].b, stim[k].sof);
    end
    for (int i = 0; i < 200 && !drained; i++) begin
      tick();
      drained = !out_valid;
    end
    ready_mode = 2'd1;
    tick();
    checks++;
    if (!drained) begin errors++; $display("FAIL rnd_drain: out_valid stuck at %b", out_valid); end
    run_model();
    checks += 2;
    if (got_q.size() - n0 != exp_q.size()) begin
      errors++; $display("FAIL rnd_count: got %0d words want %0d", got_q.size() - n0, exp_q.size());
    end
    if (err_seen - e0 != exp_errs) begin
      errors++; $display("FAIL rnd_errs: got %0d pulses want %0d", err_seen - e0, exp_errs);
    end
    for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++) begin
      checks++;
      if (got_q[n0 + i] !== exp_q[i]) begin
        errors++; $display("FAIL rnd_word[%0d]: got %h want %h", i, got_q[n0 + i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_assembly();
    test_backpressure();
    test_restart();
    test_idle_junk();
    test_reset_mid();
    if (P_EN) test_parity_bad();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
